// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences each instruction through fetch, decode, execute, memory and
// write-back steps, driving the datapath enables and mux selects. It
// handshakes with variable-latency instruction and data memories, halts
// on an illegal opcode, and counts retired instructions.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   opcode[6:0]      instruction register opcode field (valid from DECODE)
//   instReady        instruction memory has completed the fetch
//   dataReady        data memory has completed the access
//   branchTaken      branch comparator result
//   instReq, irWrite, pcWrite, pcSrc[1:0]        fetch / PC control
//   aluSrcA[1:0], aluSrcB[1:0], aluOp[1:0]       ALU control
//   dataReq, dataWe                              data memory control
//   regWrite, wbSel[1:0]                         register write-back control
//   halted, state_o[3:0], instRetired[31:0]      status / debug
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        instReady,
  input  logic        dataReady,
  input  logic        branchTaken,
  output logic        instReq,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        dataReq,
  output logic        dataWe,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic        halted,
  output logic [3:0]  state_o,
  output logic [31:0] instRetired
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_HALT   = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = instReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL:             w_next = S_JAL;
          OP_JALR:            w_next = S_JALR;
          OP_LUI:             w_next = S_LUI;
          OP_AUIPC:           w_next = S_WB_ALU;
          default:            w_next = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI: w_next = S_WB_ALU;
      S_ADDR:   w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = dataReady ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: w_next = dataReady ? S_FETCH : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;  // unused encodings 13/14
    endcase
  end

  // Output logic; reset forces every control output low
  always_comb begin
    instReq  = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 2'd0;
    aluSrcA  = 2'd0;
    aluSrcB  = 2'd0;
    aluOp    = 2'd0;
    dataReq  = 1'b0;
    dataWe   = 1'b0;
    regWrite = 1'b0;
    wbSel    = 2'd0;
    halted   = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          instReq = 1'b1;
          aluSrcA = 2'd2;
          aluSrcB = 2'd2;
          irWrite = instReady;
          pcWrite = instReady;
        end
        S_DECODE: begin
          aluSrcA = 2'd1;
          aluSrcB = 2'd1;
        end
        S_EXEC_R: aluOp = 2'b10;
        S_EXEC_I: begin
          aluSrcB = 2'd1;
          aluOp   = 2'b11;
        end
        S_LUI: begin
          aluSrcA = 2'd3;
          aluSrcB = 2'd1;
        end
        S_ADDR:   aluSrcB = 2'd1;
        S_MEM_RD: dataReq = 1'b1;
        S_MEM_WR: begin
          dataReq = 1'b1;
          dataWe  = 1'b1;
        end
        S_WB_ALU: regWrite = 1'b1;
        S_WB_MEM: begin
          regWrite = 1'b1;
          wbSel    = 2'd1;
        end
        S_BRANCH: begin
          aluOp   = 2'b01;
          pcSrc   = 2'd1;
          pcWrite = branchTaken;
        end
        S_JAL: begin
          regWrite = 1'b1;
          wbSel    = 2'd2;
          pcSrc    = 2'd1;
          pcWrite  = 1'b1;
        end
        S_JALR: begin
          aluSrcB  = 2'd1;
          pcSrc    = 2'd2;
          pcWrite  = 1'b1;
          regWrite = 1'b1;
          wbSel    = 2'd2;
        end
        S_HALT:   halted = 1'b1;
        default:  ;
      endcase
    end
  end

  // An instruction retires on any transition back into FETCH
  assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)           r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign state_o     = r_state;
  assign instRetired = r_retired;

endmodule
